oht2bin_pipe: RTL and testbench

OHT2BIN_PIPE -- requirements
Module: oht2bin_pipe

---
 rtl/oht2bin_pipe.sv | 142 ++++++++++++++
 tb/tb_oht2bin_pipe.sv | 391 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/oht2bin_pipe.sv
// Pipelined one-hot to binary encoder: a SPLIT-ary reduction tree, one registered
// level per stage, with valid/ready flow control and bubble-collapsing stalls.
module oht2bin_pipe #(
    parameter  int unsigned WIDTH     = 16,
    parameter  int unsigned SPLIT     = 4,
    localparam int unsigned WIDTH_LOG = $clog2(WIDTH),
    localparam int unsigned SPLIT_LOG = $clog2(SPLIT),
    localparam int unsigned LEVELS    = (WIDTH_LOG + SPLIT_LOG - 1) / SPLIT_LOG
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 s_vld,
    output logic                 s_rdy,
    input  logic [WIDTH-1:0]     s_oht,
    output logic                 m_vld,
    input  logic                 m_rdy,
    output logic [WIDTH_LOG-1:0] m_bin,
    output logic                 m_err
);

    logic [LEVELS-1:0] vld_q;
    logic [LEVELS-1:0] vld_d;
    logic [LEVELS-1:0] adv;

    // A stage may load when it is empty or its contents move on this edge.
    always_comb begin
        adv = '0;
        adv[LEVELS-1] = ~vld_q[LEVELS-1] | m_rdy;
        for (int k = int'(LEVELS) - 2; k >= 0; k--) begin
            adv[k] = ~vld_q[k] | adv[k+1];
        end
    end

    always_comb begin
        vld_d    = vld_q;
        vld_d[0] = adv[0] ? s_vld : vld_q[0];
        for (int k = 1; k < int'(LEVELS); k++) begin
            if (adv[k]) vld_d[k] = vld_q[k-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) vld_q <= '0;
        else        vld_q <= vld_d;
    end

    assign s_rdy = adv[0];
    assign m_vld = vld_q[LEVELS-1];

    for (genvar lv = 0; lv < int'(LEVELS); lv++) begin : g_stage
        localparam bit          LAST    = (lv == int'(LEVELS) - 1);
        localparam int unsigned IN_N    = WIDTH >> (SPLIT_LOG * lv);
        localparam int unsigned OUT_N   = LAST ? 1 : (IN_N >> SPLIT_LOG);
        localparam int unsigned GRP     = IN_N / OUT_N;
        localparam int unsigned GRP_LOG = $clog2(GRP);
        localparam int unsigned IN_IW   = SPLIT_LOG * lv;
        localparam int unsigned OUT_IW  = IN_IW + GRP_LOG;

        logic                          in_vld;
        logic [IN_N-1:0]               c_any;
        logic [IN_N-1:0]               c_flag;
        logic [OUT_N-1:0]              any_d;
        logic [OUT_N-1:0]              multi_d;
        logic [OUT_N-1:0][GRP_LOG-1:0] sel;
        logic [OUT_N-1:0][OUT_IW-1:0]  idx_raw;
        logic [OUT_N-1:0][OUT_IW-1:0]  idx_d;
        logic [OUT_N-1:0]              any_q;
        logic [OUT_N-1:0]              flag_q;
        logic [OUT_N-1:0][OUT_IW-1:0]  idx_q;

        if (lv == 0) begin : g_leaf
            assign in_vld  = s_vld;
            assign c_any   = s_oht;
            assign c_flag  = '0;
            assign idx_raw = sel;
        end else begin : g_node
            logic [IN_N-1:0][IN_IW-1:0]  c_idx;
            logic [OUT_N-1:0][IN_IW-1:0] sub;

            assign in_vld = vld_q[lv-1];
            assign c_any  = g_stage[lv-1].any_q;
            assign c_flag = g_stage[lv-1].flag_q;
            assign c_idx  = g_stage[lv-1].idx_q;

            // Lower index bits come from the active child; garbage on multi is masked later.
            always_comb begin
                sub = '0;
                for (int g = 0; g < int'(OUT_N); g++) begin
                    for (int c = 0; c < int'(GRP); c++) begin
                        if (c_any[g*GRP + c]) sub[g] = c_idx[g*GRP + c];
                    end
                end
            end

            always_comb begin
                idx_raw = '0;
                for (int g = 0; g < int'(OUT_N); g++) begin
                    idx_raw[g] = {sel[g], sub[g]};
                end
            end
        end

        // Per group: any child set, more than one set (or inherited), and which one.
        always_comb begin
            any_d   = '0;
            multi_d = '0;
            sel     = '0;
            for (int g = 0; g < int'(OUT_N); g++) begin
                for (int c = 0; c < int'(GRP); c++) begin
                    if (c_flag[g*GRP + c]) multi_d[g] = 1'b1;
                    if (c_any[g*GRP + c]) begin
                        if (any_d[g]) multi_d[g] = 1'b1;
                        any_d[g] = 1'b1;
                        sel[g]   = GRP_LOG'(c);
                    end
                end
            end
        end

        always_comb begin
            idx_d = idx_raw;
            if (LAST) begin
                for (int g = 0; g < int'(OUT_N); g++) begin
                    if (!any_d[g] || multi_d[g]) idx_d[g] = '0;
                end
            end
        end

        // Payload only loads on a real transfer into this stage; no reset needed.
        always_ff @(posedge clk) begin
            if (adv[lv] && in_vld) begin
                any_q  <= any_d;
                flag_q <= multi_d;
                idx_q  <= idx_d;
            end
        end
    end

    assign m_bin = g_stage[LEVELS-1].idx_q[0];
    assign m_err = ~g_stage[LEVELS-1].any_q[0] | g_stage[LEVELS-1].flag_q[0];

endmodule

// File: tb/tb_oht2bin_pipe.sv
// Directed and randomized checks of oht2bin_pipe at WIDTH=16, SPLIT=4.
module tb_oht2bin_pipe;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        s_vld = 1'b0;
    logic        s_rdy;
    logic [15:0] s_oht = '0;
    logic        m_vld;
    logic        m_rdy = 1'b0;
    logic [3:0]  m_bin;
    logic        m_err;

    int vec_cnt = 0;
    int err_cnt = 0;

    always #5 clk = ~clk;

    oht2bin_pipe #(.WIDTH(16), .SPLIT(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .s_vld (s_vld),
        .s_rdy (s_rdy),
        .s_oht (s_oht),
        .m_vld (m_vld),
        .m_rdy (m_rdy),
        .m_bin (m_bin),
        .m_err (m_err)
    );

    // Reference result packed as {err, bin}.
    function automatic logic [4:0] ref_enc(input logic [15:0] v);
        int         n = 0;
        logic [3:0] b = '0;
        for (int i = 0; i < 16; i++) begin
            if (v[i]) begin
                n++;
                b = 4'(i);
            end
        end
        return (n == 1) ? {1'b0, b} : 5'b10000;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        s_vld = 1'b1;
        s_oht = 16'h0001;
        m_rdy = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        vec_cnt++;
        if (m_vld !== 1'b0) begin
            err_cnt++;
            $display("FAIL reset_m_vld: got %b expected 0", m_vld);
        end
        vec_cnt++;
        if (s_rdy !== 1'b1) begin
            err_cnt++;
            $display("FAIL reset_s_rdy: got %b expected 1", s_rdy);
        end
        s_vld = 1'b0;
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_sweep();
        int in_i = 0;
        int exp_i = 0;
        int first_in = -1;
        int first_out = -1;
        int prev_out = -1;
        m_rdy = 1'b1;
        for (int cyc = 0; cyc < 60 && exp_i < 16; cyc++) begin
            s_vld = (in_i < 16);
            s_oht = (in_i < 16) ? (16'h0001 << in_i) : 16'h0000;
            @(negedge clk);
            if (m_vld) begin
                vec_cnt++;
                if ({m_err, m_bin} !== {1'b0, 4'(exp_i)}) begin
                    err_cnt++;
                    $display("FAIL sweep_data: got err=%b bin=%0d expected err=0 bin=%0d", m_err, m_bin, exp_i);
                end
                if (first_out < 0) first_out = cyc;
                else begin
                    vec_cnt++;
                    if (cyc != prev_out + 1) begin
                        err_cnt++;
                        $display("FAIL sweep_gap: output at cycle %0d expected cycle %0d", cyc, prev_out + 1);
                    end
                end
                prev_out = cyc;
                exp_i++;
            end
            if (s_vld && s_rdy) begin
                if (first_in < 0) first_in = cyc;
                in_i++;
            end
            step();
        end
        s_vld = 1'b0;
        vec_cnt++;
        if (exp_i != 16) begin
            err_cnt++;
            $display("FAIL sweep_count: got %0d outputs expected 16", exp_i);
        end
        vec_cnt++;
        if (first_out - first_in != 2) begin
            err_cnt++;
            $display("FAIL sweep_latency: got %0d cycles expected 2", first_out - first_in);
        end
    endtask

    task automatic test_errors();
        logic [15:0] vin [3] = '{16'h0000, 16'h0101, 16'h8000};
        logic [4:0]  vexp[3] = '{5'h10, 5'h10, 5'h0F};
        int in_i = 0;
        int exp_i = 0;
        m_rdy = 1'b1;
        for (int cyc = 0; cyc < 20 && exp_i < 3; cyc++) begin
            s_vld = (in_i < 3);
            s_oht = (in_i < 3) ? vin[in_i] : 16'h0000;
            @(negedge clk);
            if (m_vld) begin
                vec_cnt++;
                if ({m_err, m_bin} !== vexp[exp_i]) begin
                    err_cnt++;
                    $display("FAIL err_case_%0d: got {err,bin}=%h expected %h", exp_i, {m_err, m_bin}, vexp[exp_i]);
                end
                exp_i++;
            end
            if (s_vld && s_rdy) in_i++;
            step();
        end
        s_vld = 1'b0;
        vec_cnt++;
        if (exp_i != 3) begin
            err_cnt++;
            $display("FAIL err_case_count: got %0d outputs expected 3", exp_i);
        end
    endtask

    task automatic test_backpressure();
        int         in_i = 0;
        int         exp_i = 0;
        logic       held = 1'b0;
        logic [4:0] hold_val = '0;
        for (int cyc = 0; cyc < 80 && exp_i < 16; cyc++) begin
            s_vld = (in_i < 16);
            s_oht = (in_i < 16) ? (16'h0001 << in_i) : 16'h0000;
            m_rdy = !(cyc >= 4 && cyc < 9);
            @(negedge clk);
            if (held) begin
                vec_cnt++;
                if (m_vld !== 1'b1 || {m_err, m_bin} !== hold_val) begin
                    err_cnt++;
                    $display("FAIL bp_stable: got vld=%b {err,bin}=%h expected vld=1 %h", m_vld, {m_err, m_bin}, hold_val);
                end
            end
            if (cyc >= 4 && cyc < 9) begin
                vec_cnt++;
                if (s_rdy !== 1'b0) begin
                    err_cnt++;
                    $display("FAIL bp_s_rdy: cycle %0d got %b expected 0", cyc, s_rdy);
                end
            end
            if (m_vld && m_rdy) begin
                vec_cnt++;
                if ({m_err, m_bin} !== {1'b0, 4'(exp_i)}) begin
                    err_cnt++;
                    $display("FAIL bp_data: got err=%b bin=%0d expected err=0 bin=%0d", m_err, m_bin, exp_i);
                end
                exp_i++;
            end
            held     = m_vld && !m_rdy;
            hold_val = {m_err, m_bin};
            if (s_vld && s_rdy) in_i++;
            step();
        end
        s_vld = 1'b0;
        m_rdy = 1'b1;
        vec_cnt++;
        if (exp_i != 16) begin
            err_cnt++;
            $display("FAIL bp_count: got %0d outputs expected 16", exp_i);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            vec_cnt++;
            if (m_vld !== 1'b0) begin
                err_cnt++;
                $display("FAIL bp_extra: got m_vld=%b expected 0", m_vld);
            end
            step();
        end
    endtask

    task automatic test_bubble();
        m_rdy = 1'b0;
        s_vld = 1'b1;
        s_oht = 16'h0002;
        @(negedge clk);
        vec_cnt++;
        if (s_rdy !== 1'b1) begin
            err_cnt++;
            $display("FAIL bubble_first_rdy: got %b expected 1", s_rdy);
        end
        step();
        s_vld = 1'b0;
        step();
        @(negedge clk);
        vec_cnt++;
        if (m_vld !== 1'b1 || m_bin !== 4'd1 || s_rdy !== 1'b1) begin
            err_cnt++;
            $display("FAIL bubble_parked: got vld=%b bin=%0d s_rdy=%b expected 1 1 1", m_vld, m_bin, s_rdy);
        end
        step();
        s_vld = 1'b1;
        s_oht = 16'h0400;
        @(negedge clk);
        vec_cnt++;
        if (s_rdy !== 1'b1) begin
            err_cnt++;
            $display("FAIL bubble_second_rdy: got %b expected 1", s_rdy);
        end
        step();
        s_vld = 1'b0;
        @(negedge clk);
        vec_cnt++;
        if (s_rdy !== 1'b0 || m_vld !== 1'b1 || m_bin !== 4'd1) begin
            err_cnt++;
            $display("FAIL bubble_full: got s_rdy=%b vld=%b bin=%0d expected 0 1 1", s_rdy, m_vld, m_bin);
        end
        step();
        m_rdy = 1'b1;
        @(negedge clk);
        vec_cnt++;
        if (m_vld !== 1'b1 || {m_err, m_bin} !== 5'h01) begin
            err_cnt++;
            $display("FAIL bubble_out_a: got vld=%b {err,bin}=%h expected 1 01", m_vld, {m_err, m_bin});
        end
        step();
        @(negedge clk);
        vec_cnt++;
        if (m_vld !== 1'b1 || {m_err, m_bin} !== 5'h0A) begin
            err_cnt++;
            $display("FAIL bubble_out_b: got vld=%b {err,bin}=%h expected 1 0a", m_vld, {m_err, m_bin});
        end
        step();
        @(negedge clk);
        vec_cnt++;
        if (m_vld !== 1'b0) begin
            err_cnt++;
            $display("FAIL bubble_drain: got m_vld=%b expected 0", m_vld);
        end
        step();
    endtask

    task automatic test_mid_reset();
        m_rdy = 1'b0;
        s_vld = 1'b1;
        s_oht = 16'h0004;
        step();
        s_oht = 16'h0200;
        step();
        s_vld = 1'b0;
        vec_cnt++;
        if (m_vld !== 1'b1) begin
            err_cnt++;
            $display("FAIL mrst_inflight: got m_vld=%b expected 1", m_vld);
        end
        rst_n = 1'b0;
        #1;
        vec_cnt++;
        if (m_vld !== 1'b0 || s_rdy !== 1'b1) begin
            err_cnt++;
            $display("FAIL mrst_immediate: got m_vld=%b s_rdy=%b expected 0 1", m_vld, s_rdy);
        end
        step();
        rst_n = 1'b1;
        m_rdy = 1'b1;
        for (int cyc = 0; cyc < 4; cyc++) begin
            s_vld = (cyc == 0);
            s_oht = (cyc == 0) ? 16'h0010 : 16'h0000;
            @(negedge clk);
            if (cyc == 0) begin
                vec_cnt++;
                if (s_rdy !== 1'b1) begin
                    err_cnt++;
                    $display("FAIL mrst_accept: got s_rdy=%b expected 1", s_rdy);
                end
            end
            vec_cnt++;
            if (cyc == 2) begin
                if (m_vld !== 1'b1 || {m_err, m_bin} !== 5'h04) begin
                    err_cnt++;
                    $display("FAIL mrst_result: got vld=%b {err,bin}=%h expected 1 04", m_vld, {m_err, m_bin});
                end
            end else if (m_vld !== 1'b0) begin
                err_cnt++;
                $display("FAIL mrst_stale: cycle %0d got m_vld=%b expected 0", cyc, m_vld);
            end
            step();
        end
    endtask

    task automatic test_random();
        logic [4:0] sb[$];
        logic [4:0] exp_v;
        logic       held = 1'b0;
        logic [4:0] hold_val = '0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            s_vld = 1'($urandom_range(0, 1));
            m_rdy = 1'($urandom_range(0, 1));
            s_oht = ($urandom_range(0, 3) != 0) ? (16'h0001 << $urandom_range(0, 15)) : 16'($urandom);
            @(negedge clk);
            if (held) begin
                vec_cnt++;
                if (m_vld !== 1'b1 || {m_err, m_bin} !== hold_val) begin
                    err_cnt++;
                    $display("FAIL rnd_stable: got vld=%b {err,bin}=%h expected vld=1 %h", m_vld, {m_err, m_bin}, hold_val);
                end
            end
            if (m_vld && m_rdy) begin
                vec_cnt++;
                if (sb.size() == 0) begin
                    err_cnt++;
                    $display("FAIL rnd_extra: got {err,bin}=%h expected no output", {m_err, m_bin});
                end else begin
                    exp_v = sb.pop_front();
                    if ({m_err, m_bin} !== exp_v) begin
                        err_cnt++;
                        $display("FAIL rnd_data: got {err,bin}=%h expected %h", {m_err, m_bin}, exp_v);
                    end
                end
            end
            held     = m_vld && !m_rdy;
            hold_val = {m_err, m_bin};
            if (s_vld && s_rdy) sb.push_back(ref_enc(s_oht));
            step();
        end
        s_vld = 1'b0;
        m_rdy = 1'b1;
        for (int cyc = 0; cyc < 10; cyc++) begin
            @(negedge clk);
            if (m_vld) begin
                vec_cnt++;
                if (sb.size() == 0) begin
                    err_cnt++;
                    $display("FAIL rnd_drain_extra: got {err,bin}=%h expected no output", {m_err, m_bin});
                end else begin
                    exp_v = sb.pop_front();
                    if ({m_err, m_bin} !== exp_v) begin
                        err_cnt++;
                        $display("FAIL rnd_drain_data: got {err,bin}=%h expected %h", {m_err, m_bin}, exp_v);
                    end
                end
            end
            step();
        end
        vec_cnt++;
        if (sb.size() != 0) begin
            err_cnt++;
            $display("FAIL rnd_lost: %0d results outstanding expected 0", sb.size());
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_sweep();
        test_errors();
        test_backpressure();
        test_bubble();
        test_mid_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
